// File: rtl/wb_writer_pkg.sv
// Shared register-file widths, reset/write-enable constants and the writeback FIFO entry type.
package wb_writer_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;

  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer taking up to two pushes (a older than b) and one pop per cycle.
module wb_fifo
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = wb_entry_t,
  localparam int unsigned PtrW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_a,
  input  entry_t        data_a,
  input  logic          push_b,
  input  entry_t        data_b,
  input  logic          pop,
  output entry_t        head,
  output logic          empty,
  output logic [PtrW:0] count
);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [PtrW:0]     count_q, count_d;
  logic [PtrW-1:0]   slot_b;
  logic [1:0]        n_push;

  always_comb begin
    n_push  = {1'b0, push_a} + {1'b0, push_b};
    // b lands behind a when both arrive together
    slot_b  = push_a ? tail_q + PtrW'(1) : tail_q;
    tail_d  = tail_q + PtrW'(n_push);
    head_d  = head_q + PtrW'(pop);
    count_d = count_q + (PtrW + 1)'(n_push) - (PtrW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst != RstEnable) begin
      if (push_a) mem_q[tail_q] <= data_a;
      if (push_b) mem_q[slot_b] <= data_b;
    end
  end

  assign head  = mem_q[head_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_writer.sv
// Writeback driver: buffers EX/MEM results in order, drains one regfile write per cycle and
// tracks outstanding writes per register so ID can stall on pending operands.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 3,
  localparam int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_hold,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic [CntW-1:0]   count
);

  localparam int unsigned        RegCount = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]   CntMax   = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          head, mem_entry, ex_entry;
  logic            empty, pop, in_rst;
  logic            mem_push, ex_push;
  logic [CntW:0]   free;
  logic [CntW-1:0] fifo_count;

  always_comb begin
    in_rst    = (rst == RstEnable);
    pop       = !in_rst && !empty && !wb_hold;
    we        = pop ? WriteEnable : WriteDisable;
    waddr     = pop ? head.addr : '0;
    wdata     = pop ? head.data : '0;
    // the slot freed by this cycle's drain is reusable at the same edge
    free      = (CntW + 1)'(DEPTH) - {1'b0, fifo_count} + (CntW + 1)'(pop);
    mem_ready = !in_rst && (free >= (CntW + 1)'(1));
    ex_ready  = !in_rst && (mem_valid ? (free >= (CntW + 1)'(2)) : (free >= (CntW + 1)'(1)));
    // x0 results complete the handshake but never reach the regfile
    mem_push  = mem_valid && mem_ready && (mem_waddr != '0);
    ex_push   = ex_valid && ex_ready && (ex_waddr != '0);
    mem_entry = '{addr: mem_waddr, data: mem_wdata};
    ex_entry  = '{addr: ex_waddr, data: ex_wdata};
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_a (mem_push),
    .data_a (mem_entry),
    .push_b (ex_push),
    .data_b (ex_entry),
    .pop    (pop),
    .head   (head),
    .empty  (empty),
    .count  (fifo_count)
  );

  assign count = fifo_count;

  // Scoreboard: outstanding-write counter per architectural register.
  logic [CNT_W-1:0]    sb_q [RegCount];
  logic [CNT_W-1:0]    sb_d [RegCount];
  logic [RegCount-1:0] sb_inc, sb_dec;

  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    if (issue_valid && (issue_waddr != '0)) sb_inc[issue_waddr] = 1'b1;
    if (pop) sb_dec[head.addr] = 1'b1;
    for (int unsigned i = 0; i < RegCount; i++) begin
      sb_d[i] = sb_q[i];
      if (i != 0) begin
        if (sb_inc[i] && !sb_dec[i] && (sb_q[i] != CntMax)) begin
          sb_d[i] = sb_q[i] + CNT_W'(1);
        end else if (sb_dec[i] && !sb_inc[i] && (sb_q[i] != '0)) begin
          sb_d[i] = sb_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < RegCount; i++) begin
      if (rst == RstEnable) sb_q[i] <= '0;
      else                  sb_q[i] <= sb_d[i];
    end
  end

  // A write draining this cycle is already visible through the regfile bypass.
  logic hit1, hit2;

  always_comb begin
    hit1  = pop && (head.addr == chk_addr1);
    hit2  = pop && (head.addr == chk_addr2);
    busy1 = !in_rst && (chk_addr1 != '0) && (sb_q[chk_addr1] != CNT_W'(hit1));
    busy2 = !in_rst && (chk_addr2 != '0) && (sb_q[chk_addr2] != CNT_W'(hit2));
  end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: handshakes, drain order, backpressure, scoreboard, x0, reset.
module tb_wb_writer;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_ready, mem_valid, mem_ready;
  logic [4:0]  ex_waddr, mem_waddr, waddr, issue_waddr, chk_addr1, chk_addr2;
  logic [31:0] ex_wdata, mem_wdata, wdata;
  logic        wb_hold, we, issue_valid, busy1, busy2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_writer #(
    .DATA_W (32),
    .ADDR_W (5),
    .DEPTH  (4),
    .CNT_W  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_waddr    (ex_waddr),
    .ex_wdata    (ex_wdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .wb_hold     (wb_hold),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid    = 1'b0;
    mem_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wb_hold = 1'b0; idle();
    ex_waddr = 5'd5; ex_wdata = 32'h1; mem_waddr = 5'd6; mem_wdata = 32'h2;
    issue_waddr = '0; chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    ex_valid = 1'b1; mem_valid = 1'b1;
    #1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_ex_ready", ex_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_busy1", busy1, 0);
    tick();

    // Single EX push
    rst = 1'b0; idle();
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h1234;
    #1;
    check("post_rst_count", count, 0);
    check("single_ex_ready", ex_ready, 1);
    check("single_we_before", we, 0);
    tick();
    idle(); #1;
    check("single_we", we, 1);
    check("single_waddr", waddr, 5);
    check("single_wdata", wdata, 32'h1234);
    check("single_count", count, 1);
    tick(); #1;
    check("single_count_after", count, 0);
    check("single_we_after", we, 0);

    // Dual push: MEM before EX
    mem_valid = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hAAAA;
    ex_valid = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'hBBBB;
    #1;
    check("dual_mem_ready", mem_ready, 1);
    check("dual_ex_ready", ex_ready, 1);
    tick();
    idle(); #1;
    check("dual_count", count, 2);
    check("dual_first_addr", waddr, 3);
    check("dual_first_data", wdata, 32'hAAAA);
    tick(); #1;
    check("dual_second_we", we, 1);
    check("dual_second_addr", waddr, 4);
    check("dual_second_data", wdata, 32'hBBBB);
    tick(); #1;
    check("dual_drained_count", count, 0);

    // Backpressure under hold
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_waddr = 5'(10 + i); ex_wdata = 32'(100 + i);
      tick();
    end
    ex_valid = 1'b1; ex_waddr = 5'd20; ex_wdata = 32'd200;
    mem_valid = 1'b1; mem_waddr = 5'd13; mem_wdata = 32'd103;
    #1;
    check("hold3_count", count, 3);
    check("hold3_we", we, 0);
    check("hold3_mem_ready", mem_ready, 1);
    check("hold3_ex_ready", ex_ready, 0);
    tick();
    idle(); #1;
    check("full_count", count, 4);
    check("full_ex_ready", ex_ready, 0);
    check("full_mem_ready", mem_ready, 0);
    wb_hold = 1'b0; #1;
    check("full_pop_ex_ready", ex_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("release_we", we, 1);
      check("release_addr", waddr, 32'(10 + i));
      check("release_data", wdata, 32'(100 + i));
      tick();
    end
    check("release_done_we", we, 0);
    check("release_done_count", count, 0);

    // Scoreboard on r7
    issue_valid = 1'b1; issue_waddr = 5'd7; #1;
    check("sb_same_cycle_busy1", busy1, 0);
    tick(); #1;
    check("sb_issue1_busy1", busy1, 1);
    tick();
    idle(); ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'd71; #1;
    check("sb_issue2_busy1", busy1, 1);
    tick();
    ex_wdata = 32'd72; #1;
    check("sb_drain1_data", wdata, 32'd71);
    check("sb_drain1_busy1", busy1, 1);
    check("sb_busy2", busy2, 0);
    tick();
    idle(); #1;
    check("sb_drain2_data", wdata, 32'd72);
    check("sb_drain2_busy1", busy1, 0);
    tick(); #1;
    check("sb_idle_busy1", busy1, 0);

    // x0 handling
    ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hDEAD; #1;
    check("x0_ex_ready", ex_ready, 1);
    tick();
    idle(); issue_valid = 1'b1; issue_waddr = 5'd0; chk_addr1 = 5'd0; #1;
    check("x0_count", count, 0);
    check("x0_we", we, 0);
    tick();
    idle(); #1;
    check("x0_busy1", busy1, 0);
    check("x0_we_later", we, 0);

    // Reset mid-operation
    chk_addr1 = 5'd1; chk_addr2 = 5'd9;
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ex_valid = 1'b1; ex_waddr = 5'(i); ex_wdata = 32'(i);
      issue_valid = (i == 1); issue_waddr = 5'd9;
      tick();
    end
    idle(); #1;
    check("mid_count", count, 3);
    check("mid_busy2", busy2, 1);
    rst = 1'b1; wb_hold = 1'b0; #1;
    check("mid_rst_we", we, 0);
    check("mid_rst_busy2", busy2, 0);
    tick();
    rst = 1'b0; #1;
    check("mid_after_count", count, 0);
    check("mid_after_busy1", busy1, 0);
    check("mid_after_busy2", busy2, 0);
    check("mid_after_we", we, 0);
    tick(); #1;
    check("mid_no_stale_we", we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
